// File: rtl/aes_s_box.sv
// AES forward S-box: GF(2^8) inverse (as x^254) followed by the FIPS-197 affine map.
// Provides both the combinational result and a one-cycle registered copy.
module aes_s_box (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    output logic [7:0] out,
    output logic [7:0] out_q
);

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        gf_mul = p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        rotl = d[15:8];
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; this also maps 0 to 0 with no special case.
    logic [7:0] sq [1:7];
    logic [7:0] inv;
    logic [7:0] prod;

    always_comb begin
        sq[1] = gf_mul(in, in);
        for (int k = 2; k <= 7; k++) begin
            sq[k] = gf_mul(sq[k-1], sq[k-1]);
        end
        prod = sq[1];
        for (int k = 2; k <= 7; k++) begin
            prod = gf_mul(prod, sq[k]);
        end
        inv = prod;
    end

    assign out = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= 8'h00;
        else        out_q <= out;
    end

endmodule

// File: tb/tb_aes_s_box.sv
// Bench for aes_s_box: spot table, exhaustive sweep against a search-based model,
// reset/latency corner sequences and a scoreboarded random stream on out_q.
module tb_aes_s_box;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [7:0] out;
    logic [7:0] out_q;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
    } vec_t;

    vec_t spot [8];

    aes_s_box dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (din),
        .out   (out),
        .out_q (out_q)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    // reference model: shift-and-add multiply, inverse by search, bitwise affine
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) acc = acc ^ ({8'h00, b} << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
        end
        ref_mul = acc[7:0];
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] r;
        b = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && ref_mul(x, y[7:0]) == 8'h01) b = y[7:0];
        end
        c = 8'h63;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
        end
        ref_sbox = r;
    endfunction

    // driver / checker tasks
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        din = v;
        exp_q.push_back(ref_sbox(v));
    endtask

    task automatic sb_check(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got empty queue expected entry", name);
        end else begin
            e = exp_q.pop_front();
            check(name, out_q, e);
        end
    endtask

    initial begin
        spot[0] = '{8'h00, 8'h63};
        spot[1] = '{8'h01, 8'h7c};
        spot[2] = '{8'h02, 8'h77};
        spot[3] = '{8'h10, 8'hca};
        spot[4] = '{8'h53, 8'hed};
        spot[5] = '{8'h80, 8'hcd};
        spot[6] = '{8'haa, 8'hac};
        spot[7] = '{8'hff, 8'h16};

        // reset behaviour: out live while out_q held at zero
        rst_n = 1'b0;
        din   = 8'h01;
        #12;
        check("reset_out_q", out_q, 8'h00);
        check("reset_out", out, 8'h7c);
        @(posedge clk);
        #1;
        check("reset_out_q_edge", out_q, 8'h00);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_out_q", out_q, 8'h7c);

        // spot table on the combinational path
        for (int i = 0; i < 8; i++) begin
            din = spot[i].x;
            #1;
            check($sformatf("spot_%02h", spot[i].x), out, spot[i].y);
        end

        // exhaustive sweep against the model
        for (int v = 0; v < 256; v++) begin
            din = v[7:0];
            #10;
            check($sformatf("sweep_%02h", v[7:0]), out, ref_sbox(v[7:0]));
        end

        // registered latency: 53 then FF just after an edge
        @(posedge clk);
        #1;
        din = 8'h53;
        @(posedge clk);
        #1;
        check("lat_53", out_q, 8'hed);
        din = 8'hff;
        #3;
        check("lat_hold", out_q, 8'hed);
        check("lat_comb_ff", out, 8'h16);
        @(posedge clk);
        #1;
        check("lat_ff", out_q, 8'h16);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_q", out_q, 8'h00);
        check("async_rst_out", out, 8'h16);
        #1;
        rst_n = 1'b1;
        #1;
        check("async_rel_no_edge", out_q, 8'h00);
        @(posedge clk);
        #1;
        check("async_rel_edge", out_q, 8'h16);

        // scoreboarded random stream on out_q
        drive(8'($urandom_range(0, 255)));
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            sb_check("stream");
            drive(8'($urandom_range(0, 255)));
        end
        @(posedge clk);
        #1;
        sb_check("stream_last");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
